// File: rtl/pll_rstseq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_rstseq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYC      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 2000;
  localparam int DEF_STABLE_CYC       = 256;
  localparam int DEF_NUM_STAGES       = 3;
  localparam int DEF_STAGE_GAP_CYC    = 8;

  localparam logic [7:0] CNT_SAT = 8'hFF;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Event counters stick at CNT_SAT instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != CNT_SAT)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings a PLL out of reset, waits for stable lock, then releases staged resets.
// Optional loss-of-lock counter enabled by `PLL_RSTSEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int STABLE_CYC       = DEF_STABLE_CYC,
  parameter int NUM_STAGES       = DEF_NUM_STAGES,
  parameter int STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC
) (
  input  logic                  clk_in,
  input  logic                  areset,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] srst,
  output logic                  ready,
  output logic [7:0]            retry_cnt,
  output logic [7:0]            loss_cnt
);

  localparam int MAX_CYC = max4(PLL_RST_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC, STAGE_GAP_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int STG_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [STG_W-1:0] stg_t;

  state_e                state, state_nxt;
  cnt_t                  cnt, cnt_nxt;
  stg_t                  stg, stg_nxt;
  logic [NUM_STAGES-1:0] srst_q, srst_nxt;
  logic                  ready_q, ready_nxt;
  logic                  pll_rst_q;
  logic [7:0]            retry_q;
  logic                  retry_inc;
  logic                  lock_s;

  sync_2ff u_lock_sync (
    .clk (clk_in),
    .rst (areset),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + cnt_t'(1);
    stg_nxt   = stg;
    srst_nxt  = srst_q;
    ready_nxt = ready_q;
    retry_inc = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == cnt_t'(PLL_RST_CYC - 1)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == cnt_t'(LOCK_TIMEOUT_CYC - 1)) begin
          state_nxt = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        // A single dropout restarts qualification without re-pulsing the PLL.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == cnt_t'(STABLE_CYC - 1)) begin
          srst_nxt[0] = 1'b0;
          stg_nxt     = stg_t'(1);
          if (NUM_STAGES == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
          srst_nxt  = '1;
          ready_nxt = 1'b0;
        end else if (cnt == cnt_t'(STAGE_GAP_CYC - 1)) begin
          srst_nxt[stg] = 1'b0;
          cnt_nxt       = '0;
          if (stg == stg_t'(NUM_STAGES - 1)) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            stg_nxt = stg + stg_t'(1);
          end
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = PLL_RST;
          srst_nxt  = '1;
          ready_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        srst_nxt  = '1;
        ready_nxt = 1'b0;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) begin
      state     <= PLL_RST;
      cnt       <= '0;
      stg       <= '0;
      srst_q    <= '1;
      ready_q   <= 1'b0;
      pll_rst_q <= 1'b1;
      retry_q   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stg       <= stg_nxt;
      srst_q    <= srst_nxt;
      ready_q   <= ready_nxt;
      pll_rst_q <= (state_nxt == PLL_RST);
      retry_q   <= sat_inc(retry_q, retry_inc);
    end
  end

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_inc;

  assign loss_inc = (state == RUN) && !lock_s;

  always_ff @(posedge clk_in or posedge areset) begin
    if (areset) loss_q <= '0;
    else        loss_q <= sat_inc(loss_q, loss_inc);
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign srst      = srst_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with their cycle,
// a negedge monitor pops one entry per observed output change and compares.
module tb_pll_reset_sequencer;

  localparam int NS = 3;
  localparam int SW = NS + 18;

  logic          clk_in = 1'b0;
  logic          areset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [NS-1:0] srst;
  logic          ready;
  logic [7:0]    retry_cnt;
  logic [7:0]    loss_cnt;

  pll_reset_sequencer #(
    .PLL_RST_CYC      (4),
    .LOCK_TIMEOUT_CYC (100),
    .STABLE_CYC       (10),
    .NUM_STAGES       (NS),
    .STAGE_GAP_CYC    (5)
  ) dut (
    .clk_in     (clk_in),
    .areset     (areset),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .srst       (srst),
    .ready      (ready),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int            cyc;
    logic [SW-1:0] snap;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            t0 = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [SW-1:0] prev = 'x;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  localparam logic [7:0] L1 = 8'd1;
`else
  localparam logic [7:0] L1 = 8'd0;
`endif

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic push(input int c, input logic p, input logic [NS-1:0] s, input logic r,
                      input logic [7:0] rc, input logic [7:0] lc, input string n);
    exp_t e;
    e.cyc  = c;
    e.snap = {p, s, r, rc, lc};
    e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: every change of the output bundle must match the next queued entry.
  always @(negedge clk_in) begin
    logic [SW-1:0] snap;
    exp_t          e;
    int            rel;
    snap = {pll_rst, srst, ready, retry_cnt, loss_cnt};
    if (snap !== prev) begin
      prev = snap;
      rel  = cyc - t0;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_change: got %h at cycle %0d, required no change", snap, rel);
      end else begin
        e = sb.pop_front();
        if (snap === e.snap && (e.cyc < 0 || rel == e.cyc))
          n_pass++;
        else
          $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                   e.name, snap, rel, e.snap, e.cyc);
      end
    end
  end

  task automatic at_cyc(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic do_release();
    @(posedge clk_in);
    #2;
    areset = 1'b0;
    t0     = cyc;
  endtask

  task automatic do_reset(input int c, input string n);
    push(c, 1'b1, '1, 1'b0, 8'd0, 8'd0, n);
    areset     = 1'b1;
    pll_locked = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    push(-1, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0, "reset_state");
    repeat (3) @(posedge clk_in);

    // Normal bring-up: lock at cycle 30, visible to the FSM at 32, STABLE 33..42.
    do_release();
    push(4,  1'b0, 3'b111, 1'b0, 8'd0, 8'd0, "s1_pll_rst_low");
    push(43, 1'b0, 3'b110, 1'b0, 8'd0, 8'd0, "s1_srst0");
    push(48, 1'b0, 3'b100, 1'b0, 8'd0, 8'd0, "s1_srst1");
    push(53, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0, "s1_ready");
    at_cyc(30); pll_locked = 1'b1;

    // Loss in RUN: drop at 60, seen at 62, reaction at 63.
    at_cyc(60); pll_locked = 1'b0;
    push(63, 1'b1, 3'b111, 1'b0, 8'd0, L1, "s2_loss");
    push(67, 1'b0, 3'b111, 1'b0, 8'd0, L1, "s2_pll_rst_low");
    at_cyc(80); pll_locked = 1'b1;
    push(93, 1'b0, 3'b110, 1'b0, 8'd0, L1, "s2_srst0");

    // areset during RELEASE takes effect in the same cycle; full sequence repeats.
    at_cyc(95);
    do_reset(95, "s4_areset_in_release");
    pll_locked = 1'b1;
    repeat (3) @(posedge clk_in);
    do_release();
    push(4,  1'b0, 3'b111, 1'b0, 8'd0, 8'd0, "s4_pll_rst_low");
    push(15, 1'b0, 3'b110, 1'b0, 8'd0, 8'd0, "s4_srst0");
    push(20, 1'b0, 3'b100, 1'b0, 8'd0, 8'd0, "s4_srst1");
    push(25, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0, "s4_ready");

    // Glitch in STABLE: one low cycle at 19 pushes release from 23 to 31, no pll_rst.
    at_cyc(45);
    do_reset(45, "s3_areset");
    repeat (3) @(posedge clk_in);
    do_release();
    push(4,  1'b0, 3'b111, 1'b0, 8'd0, 8'd0, "s3_pll_rst_low");
    push(31, 1'b0, 3'b110, 1'b0, 8'd0, 8'd0, "s3_srst0");
    push(36, 1'b0, 3'b100, 1'b0, 8'd0, 8'd0, "s3_srst1");
    push(41, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0, "s3_ready");
    at_cyc(10); pll_locked = 1'b1;
    at_cyc(17); pll_locked = 1'b0;
    at_cyc(18); pll_locked = 1'b1;

    // No lock: re-pulse every 104 cycles, retry_cnt saturating at 255.
    at_cyc(50);
    do_reset(50, "s5_areset");
    repeat (3) @(posedge clk_in);
    do_release();
    push(4, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0, "s5_pll_rst_low");
    for (int k = 1; k <= 257; k++) begin
      logic [7:0] rc;
      rc = (k > 255) ? 8'd255 : 8'(k);
      push(104 * k,     1'b1, 3'b111, 1'b0, rc, 8'd0, $sformatf("s5_retry_%0d_pulse", k));
      push(104 * k + 4, 1'b0, 3'b111, 1'b0, rc, 8'd0, $sformatf("s5_retry_%0d_low", k));
    end
    at_cyc(104 * 257 + 10);

    n_chk++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL missing_events: got %0d unobserved (next %s at cycle %0d), required 0",
               sb.size(), sb[0].name, sb[0].cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
